// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit: memory-op codes,
//               RV32 load/store funct3 values, write-back error causes,
//               FSM state encoding and the default bus-timeout length.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Operation class presented by the execute stage
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;
  localparam logic [1:0] MEM_RSVD  = 2'b11;

  // RV32 load/store funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Write-back error causes
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Purely combinational byte-lane steering for the LSU.
//               Produces store byte enables and lane-replicated write data,
//               aligns and extends load data, and flags illegal funct3 and
//               misaligned accesses.
// Ports       : is_store   - 1 for a store, 0 for a load
//               funct3     - RV32 load/store funct3
//               off        - byte offset, addr[1:0]
//               store_data - rs2 value
//               rdata      - raw memory read word
//               be         - byte enables
//               wdata      - replicated store data
//               load_data  - shifted and extended load result
//               misaligned - half/word access not naturally aligned
//               illegal    - funct3 not legal for the op type
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = 32'h0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    shifted    = rdata >> {off, 3'b000};

    if (is_store) begin
      illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    end else begin
      illegal = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                  (funct3 == F3_BU) || (funct3 == F3_HU));
    end

    // funct3[1:0] encodes access size for both loads and stores
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << off;
        wdata      = {2{store_data[15:0]}};
        misaligned = off[0];
      end
      default: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (off != 2'b00);
      end
    endcase

    // Illegal encodings take precedence over alignment
    if (illegal) begin
      misaligned = 1'b0;
    end

    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/lsu_module.sv
`default_nettype none
// ============================================================================
// Module      : lsu_module
// Description : RV32 load/store unit downstream of the ALU. Accepts one op
//               from the execute stage, runs a single req/ack data-memory
//               transaction (with bus timeout), and returns one write-back
//               beat. Fault paths (illegal funct3, misalignment) skip the
//               memory access and complete in one cycle.
// Ports       : clk, rst_n          - clock, async active-low reset
//               ex_valid/ex_ready   - execute-stage handshake
//               mem_op, funct3      - op class and RV32 funct3
//               addr, store_data    - effective address, rs2 value
//               rd_in               - load destination register
//               dmem_*              - data-memory request/response
//               wb_*                - write-back beat
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_module
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic [1:0]  wb_cause
);

  lsu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Latched op context
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;

  // Registered outputs
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_err_q, wb_err_d;
  logic [1:0]  wb_cause_q, wb_cause_d;

  // Lane aligner sees the live op in IDLE (for accept-time checks and store
  // lanes) and the latched context afterwards (for load extension).
  logic        al_is_store;
  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_misaligned;
  logic        al_illegal;
  logic        accept;

  assign ex_ready = (state_q == ST_IDLE);
  assign accept   = ex_valid && ex_ready &&
                    ((mem_op == MEM_LOAD) || (mem_op == MEM_STORE));

  assign al_is_store = (state_q == ST_IDLE) ? (mem_op == MEM_STORE) : store_q;
  assign al_funct3   = (state_q == ST_IDLE) ? funct3 : funct3_q;
  assign al_off      = (state_q == ST_IDLE) ? addr[1:0] : off_q;

  lsu_lane_align u_align (
    .is_store   (al_is_store),
    .funct3     (al_funct3),
    .off        (al_off),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = wb_we_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_err_d     = wb_err_q;
    wb_cause_d   = wb_cause_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          store_d  = (mem_op == MEM_STORE);
          funct3_d = funct3;
          off_d    = addr[1:0];
          rd_d     = rd_in;
          addr_d   = addr;
          cnt_d    = '0;
          if (al_illegal || al_misaligned) begin
            state_d    = ST_DONE;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = rd_in;
            wb_data_d  = addr;
            wb_err_d   = 1'b1;
            wb_cause_d = al_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          end else begin
            state_d      = ST_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = (mem_op == MEM_STORE);
            dmem_addr_d  = {addr[31:2], 2'b00};
            dmem_be_d    = al_be;
            dmem_wdata_d = al_wdata;
          end
        end
      end

      ST_REQ: begin
        if (dmem_ack) begin
          state_d    = ST_DONE;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = !store_q && (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = store_q ? 32'h0 : al_load_data;
          wb_err_d   = 1'b0;
          wb_cause_d = CAUSE_NONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d    = ST_DONE;
            dmem_req_d = 1'b0;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = rd_q;
            wb_data_d  = addr_q;
            wb_err_d   = 1'b1;
            wb_cause_d = CAUSE_TIMEOUT;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      addr_q       <= 32'h0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_be_q    <= 4'h0;
      dmem_wdata_q <= 32'h0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'h0;
      wb_err_q     <= 1'b0;
      wb_cause_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_err_q     <= wb_err_d;
      wb_cause_q   <= wb_cause_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_err     = wb_err_q;
  assign wb_cause   = wb_cause_q;

endmodule : lsu_module
`default_nettype wire

// File: tb/tb_lsu_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_module
// Description : Scoreboard testbench for lsu_module. Stimulus pushes the
//               expected write-back beat; a monitor pops and compares on
//               every wb_valid. Memory-side request fields are checked by
//               the stimulus tasks acting as the memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  mem_op;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic [1:0]  wb_cause;

  always #5 clk = ~clk;

  lsu_module #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_op(mem_op), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .wb_cause(wb_cause)
  );

  // Expected write-back beat; chk_data gates rd/data (not meaningful for stores)
  typedef struct packed {
    logic        we;
    logic        err;
    logic [1:0]  cause;
    logic        chk_data;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got wb_data %h with nothing expected", wb_data);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        check("wb_ctl", {60'h0, wb_we, wb_err, wb_cause}, {60'h0, e.we, e.err, e.cause});
        if (e.chk_data)
          check("wb_rd_data", {27'h0, wb_rd, wb_data}, {27'h0, e.rd, e.data});
      end
    end
  end

  function automatic wb_exp_t mk(input logic we, input logic err, input logic [1:0] cause,
                                 input logic chk, input logic [4:0] rd, input logic [31:0] data);
    wb_exp_t e;
    e.we = we; e.err = err; e.cause = cause; e.chk_data = chk; e.rd = rd; e.data = data;
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ex_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ex_ready) check("ready_timeout", 64'(ex_ready), 64'd1);
  endtask

  // Present one op and return #1 after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd);
    wait_ready();
    ex_valid = 1'b1; mem_op = op; funct3 = f3; addr = a; store_data = sd; rd_in = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_op = 2'b00;
  endtask

  // Memory responder: check the request, ack after delay cycles
  task automatic serve(input string name, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input int delay,
                       input logic [31:0] rdata);
    check({name, "_req"}, {dmem_req, dmem_we, dmem_be, dmem_addr, 22'h0},
                          {1'b1, we, be, a, 22'h0});
    if (we) check({name, "_wdata"}, 64'(dmem_wdata), 64'(wd));
    repeat (delay) begin @(posedge clk); #1; end
    check({name, "_hold"}, {dmem_req, dmem_we, dmem_be, dmem_addr, 22'h0},
                           {1'b1, we, be, a, 22'h0});
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    check({name, "_req_drop"}, 64'(dmem_req), 64'd0);
    wait_ready();
  endtask

  // Fault op: no request, wb_valid one cycle after accept
  task automatic fault_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [4:0] rd, input logic [1:0] cause);
    exp_q.push_back(mk(1'b0, 1'b1, cause, 1'b1, rd, a));
    issue(op, f3, a, 32'h0, rd);
    check({name, "_lat"}, {62'h0, dmem_req, wb_valid}, {62'h0, 1'b0, 1'b1});
    wait_ready();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; ex_valid = 1'b0; mem_op = 2'b00; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; rd_in = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    check("reset_outs", {dmem_req, dmem_we, dmem_be, wb_valid, wb_we, wb_err, wb_cause, ex_ready},
                        {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1});
    check("reset_data", {dmem_addr, wb_data}, 64'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // SW, ack two cycles after request
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0));
    issue(2'b10, 3'b010, 32'h100, 32'hDEADBEEF, 5'd5);
    serve("sw", 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 2, 32'h0);

    // LB / LBU at byte 3, immediate ack
    exp_q.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 5'd7, 32'hFFFFFF80));
    issue(2'b01, 3'b000, 32'h203, 32'h0, 5'd7);
    serve("lb", 1'b0, 32'h200, 4'b1000, 32'h0, 0, 32'h80FF7F01);

    exp_q.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 5'd8, 32'h00000080));
    issue(2'b01, 3'b100, 32'h203, 32'h0, 5'd8);
    serve("lbu", 1'b0, 32'h200, 4'b1000, 32'h0, 0, 32'h80FF7F01);

    // SH / LH / LHU on the upper half
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0));
    issue(2'b10, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
    serve("sh", 1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 1, 32'h0);

    exp_q.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 5'd9, 32'hFFFF8001));
    issue(2'b01, 3'b001, 32'h102, 32'h0, 5'd9);
    serve("lh", 1'b0, 32'h100, 4'b1100, 32'h0, 0, 32'h80010000);

    exp_q.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 5'd10, 32'h0000BEEF));
    issue(2'b01, 3'b101, 32'h102, 32'h0, 5'd10);
    serve("lhu", 1'b0, 32'h100, 4'b1100, 32'h0, 3, 32'hBEEF1234);

    // SB at byte 1
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0));
    issue(2'b10, 3'b000, 32'h101, 32'h000000A5, 5'd0);
    serve("sb", 1'b1, 32'h100, 4'b0010, 32'hA5A5A5A5, 0, 32'h0);

    // Fault paths
    fault_op("lw_misalign", 2'b01, 3'b010, 32'h101, 5'd4, 2'b01);
    fault_op("lh_misalign", 2'b01, 3'b001, 32'h203, 5'd4, 2'b01);
    fault_op("ld_illegal", 2'b01, 3'b011, 32'h100, 5'd6, 2'b11);
    fault_op("st_illegal", 2'b10, 3'b100, 32'h100, 5'd6, 2'b11);

    // Reserved mem_op is ignored
    ex_valid = 1'b1; mem_op = 2'b11; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_op = 2'b00;
    check("rsvd_ignored", {62'h0, ex_ready, dmem_req}, {62'h0, 1'b1, 1'b0});

    // Bus timeout: request held 16 cycles
    exp_q.push_back(mk(1'b0, 1'b1, 2'b10, 1'b1, 5'd11, 32'h300));
    issue(2'b01, 3'b010, 32'h300, 32'h0, 5'd11);
    cnt = 0;
    while (dmem_req && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("timeout_len", 64'(cnt), 64'd16);
    wait_ready();

    // LW to x0: no register write
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 32'h12345678));
    issue(2'b01, 3'b010, 32'h400, 32'h0, 5'd0);
    serve("lw_x0", 1'b0, 32'h400, 4'b1111, 32'h0, 1, 32'h12345678);

    // Reset during REQ abandons the transaction
    issue(2'b01, 3'b010, 32'h500, 32'h0, 5'd3);
    check("rst_pre_req", 64'(dmem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid", {61'h0, dmem_req, ex_ready, wb_valid}, {61'h0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", {62'h0, ex_ready, dmem_req}, {62'h0, 1'b1, 1'b0});

    // Stray ack in IDLE has no effect
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(posedge clk); #1;
    check("stray_ack", {62'h0, ex_ready, dmem_req}, {62'h0, 1'b1, 1'b0});

    // Normal SW after reset
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0));
    issue(2'b10, 3'b010, 32'h604, 32'hCAFEF00D, 5'd1);
    serve("sw_post_rst", 1'b1, 32'h604, 4'b1111, 32'hCAFEF00D, 1, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_lsu_module
`default_nettype wire

// File: doc/lsu_module.md
Name: lsu_module

Overview:
- Load/store unit sitting directly downstream of the ALU in the RV32 execute path.
- Takes the ALU result as the effective address, plus rs2 data and funct3.
- Runs one data-memory transaction over a req/ack handshake, performs byte-lane alignment and load sign/zero extension, and returns a single write-back beat.
- Blocks the execute stage through ex_ready while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without dmem_ack before a bus-timeout error.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents an op.
- ex_ready  out  1  LSU can accept; high only in IDLE.
- mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- funct3  in  3  RV32 load/store funct3.
- addr  in  32  effective address (ALU res).
- store_data  in  32  rs2 value.
- rd_in  in  5  load destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completes the request this cycle.
- dmem_rdata  in  32  read word; valid when dmem_ack=1.
- wb_valid  out  1  one-cycle completion pulse.
- wb_we  out  1  write wb_data to wb_rd.
- wb_rd  out  5  destination register.
- wb_data  out  32  load result; on error, the faulting addr.
- wb_err  out  1  completion carries an error.
- wb_cause  out  2  01 misaligned, 10 bus timeout, 11 illegal funct3.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and the counter clears.
  - All registered outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_*.
  - ex_ready is decoded from state, so it is 1 in IDLE, including during reset.
  - Reset mid-transaction abandons the request with no wb_valid.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Accept when ex_valid & ex_ready & mem_op∈{01,10}. Any other mem_op is ignored and the state stays IDLE.
  - On accept, latch funct3, addr[1:0], rd_in and the op type.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW. Any other funct3 → IDLE→DONE with cause 11, no memory access.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) → IDLE→DONE with cause 01, no memory access.
  - Otherwise → REQ, with dmem_req=1 in the next cycle.
- REQ:
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until the ack.
  - On dmem_ack=1: capture dmem_rdata and go to DONE. An ack in the first REQ cycle is legal.
  - The counter increments each REQ cycle without ack. Reaching TIMEOUT_CYCLES → dmem_req=0, go to DONE with cause 10.
- DONE:
  - wb_valid=1 for exactly one cycle, then IDLE. ex_ready=0.
  - dmem_req is deasserted on the cycle after the ack.
- Latency: accept at cycle 0, dmem_req at cycle 1, ack at cycle k≥1, wb_valid at cycle k+1. Fault paths: wb_valid at cycle 1.
- Byte lanes, with off=addr[1:0]:
  - dmem_be: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111.
  - dmem_wdata: byte {4{sd[7:0]}}; half {2{sd[15:0]}}; word sd.
  - Loads: shift rdata right by 8*off, then extend. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Write-back:
  - Load success: wb_we = (wb_rd≠0).
  - Store, or any error: wb_we=0.
  - wb_err=1 exactly when the cause is nonzero; cause is 00 on success.
- dmem_ack while in IDLE or DONE is ignored.
- ex_valid while busy is not accepted. The upstream stage holds the op until ex_ready=1.

Decomposition:
- Package lsu_pkg holds: mem_op codes, funct3 constants, cause codes, the IDLE/REQ/DONE state encoding, and the default TIMEOUT_CYCLES.
- One combinational sub-module, lsu_lane_align: (funct3, off, store_data, rdata) → (be, wdata, load_data, misaligned, illegal).
- The FSM and counter stay in lsu_module.

Test Plan:
- SW, addr=0x100, sd=0xDEADBEEF, ack 2 cycles after req → dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; one wb_valid, wb_we=0, wb_err=0.
- LB, addr=0x203, rdata=0x80FF7F01 ack immediately → be=1000, wb_data=0xFFFFFF80, wb_we=1, wb_rd=rd_in. Repeat with LBU → wb_data=0x00000080.
- SH, addr=0x102, sd=0x1234ABCD → be=1100, wdata=0xABCDABCD. LH, addr=0x102, rdata=0x8001_0000 → wb_data=0xFFFF8001.
- LW, addr=0x101 → no dmem_req; wb_valid at cycle 1 with wb_err=1, cause=01, wb_data=0x101. funct3=011 → cause=11.
- Load with ack never asserted → dmem_req high for 16 cycles, then drops; wb_valid with cause=10. LW to rd=0 with ack → wb_we=0.
- rst_n pulled low in REQ → dmem_req=0 immediately, no wb_valid. After release, ex_ready=1 and a new SW completes normally. Stray dmem_ack in IDLE → no effect.
